// File: rtl/or_reduce_pipe.sv
// Pipelined FANIN-ary OR/NOR/AND/NAND reduction tree, one register rank per level,
// with valid/ready flow control and per-stage bubble collapsing.
module or_reduce_pipe #(
  parameter int WIDTH = 16,
  parameter int FANIN = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             q,
  output logic             q_valid,
  input  logic             q_ready
);

  // Number of partial bits held by stage k: ceil(WIDTH / FANIN^(k+1)).
  function automatic int stage_w(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i <= k; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int calc_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LEVELS = calc_levels();

  logic [LEVELS-1:0]   valid_vec;
  logic [LEVELS-1:0]   load_vec;
  // Chunk k is the mode presented to stage k; chunk 0 comes straight from the port.
  logic [2*LEVELS-1:0] mode_chain;

  assign mode_chain[1:0] = mode;
  assign in_ready        = load_vec[0] & rstb;

  for (genvar gi = 0; gi < LEVELS; gi++) begin : stage
    localparam int WI = (gi == 0) ? WIDTH : stage_w(gi - 1);
    localparam int WO = stage_w(gi);

    logic [WI-1:0] din;
    logic [1:0]    mode_in;
    logic          valid_in;
    logic [WO-1:0] node;
    logic [WO-1:0] data_reg;
    logic          valid_reg;

    assign mode_in       = mode_chain[2*gi +: 2];
    assign valid_vec[gi] = valid_reg;

    if (gi == 0) begin : g_src
      assign din      = in;
      assign valid_in = in_valid;
    end else begin : g_src
      assign din      = stage[gi-1].data_reg;
      assign valid_in = valid_vec[gi-1];
    end

    // Missing tree inputs are tied to the identity of the selected operator.
    for (genvar gj = 0; gj < WO; gj++) begin : g_node
      logic [FANIN-1:0] grp;
      for (genvar gk = 0; gk < FANIN; gk++) begin : g_in
        if (gj * FANIN + gk < WI) begin : g_real
          assign grp[gk] = din[gj*FANIN+gk];
        end else begin : g_pad
          assign grp[gk] = mode_in[1];
        end
      end
      assign node[gj] = mode_in[1] ? (&grp) : (|grp);
    end

    if (gi == LEVELS - 1) begin : g_last
      assign load_vec[gi] = ~valid_reg | q_ready;
      assign q            = data_reg[0];
      assign q_valid      = valid_reg;

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (load_vec[gi]) begin
          valid_reg <= valid_in;
          if (valid_in) data_reg <= node ^ mode_in[0];
        end
      end
    end else begin : g_mid
      logic [1:0] mode_reg;

      assign load_vec[gi]               = ~valid_reg | load_vec[gi+1];
      assign mode_chain[2*(gi+1) +: 2]  = mode_reg;

      // Data only moves with a valid item, so bubbles leave the registers untouched.
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          mode_reg  <= 2'b00;
        end else if (load_vec[gi]) begin
          valid_reg <= valid_in;
          if (valid_in) begin
            data_reg <= node;
            mode_reg <= mode_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Self-checking bench for or_reduce_pipe: directed scenarios plus randomized traffic
// against a scoreboard built from the any/all definition of each mode.
module tb_or_reduce_pipe;

  localparam int LEV_A = 2;   // WIDTH=16, FANIN=4

  logic        clk;
  logic        rstb;

  logic [15:0] in_a;
  logic [1:0]  mode_a;
  logic        in_valid_a, in_ready_a, q_a, q_valid_a, q_ready_a;

  logic [4:0]  in_b;
  logic [1:0]  mode_b;
  logic        in_valid_b, in_ready_b, q_b, q_valid_b, q_ready_b;

  int n_cmp;
  int n_bad;

  logic [15:0] src_in[$];
  logic [1:0]  src_mode[$];
  logic        out_q[$];
  int          acc_cnt;
  int          hold_err;
  int          stall_cyc;
  int          last_cyc;
  logic        last_in_ready;

  or_reduce_pipe #(.WIDTH(16), .FANIN(4)) dut_a (
    .clk(clk), .rstb(rstb), .in(in_a), .mode(mode_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .q(q_a), .q_valid(q_valid_a), .q_ready(q_ready_a)
  );

  or_reduce_pipe #(.WIDTH(5), .FANIN(4)) dut_b (
    .clk(clk), .rstb(rstb), .in(in_b), .mode(mode_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .q(q_b), .q_valid(q_valid_b), .q_ready(q_ready_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: OR modes ask "any bit set", AND modes ask "all bits set"; bit 0 inverts.
  function automatic logic ref_reduce(input logic [15:0] v, input logic [1:0] m);
    logic any_set;
    logic all_set;
    logic r;
    any_set = (v != 16'h0000);
    all_set = (v == 16'hFFFF);
    r = m[1] ? all_set : any_set;
    return r ^ m[0];
  endfunction

  // Drives queued items into dut_a with the given valid/ready percentages and collects outputs.
  task automatic run_a(input int n, input int pv, input int pr, input int budget);
    int   cyc;
    logic prev_hold;
    logic prev_q;
    cyc = 0;
    prev_hold = 1'b0;
    prev_q = 1'b0;
    while (out_q.size() < n && cyc < budget) begin
      in_valid_a = (acc_cnt < n) && ($urandom_range(99) < pv);
      if (acc_cnt < n) begin
        in_a   = src_in[acc_cnt];
        mode_a = src_mode[acc_cnt];
      end
      q_ready_a = ($urandom_range(99) < pr);
      @(negedge clk);
      if (prev_hold && (q_valid_a !== 1'b1 || q_a !== prev_q)) hold_err++;
      prev_hold = q_valid_a && !q_ready_a;
      prev_q = q_a;
      last_in_ready = in_ready_a;
      if (in_valid_a && !in_ready_a) stall_cyc++;
      if (in_valid_a && in_ready_a) acc_cnt++;
      if (q_valid_a && q_ready_a) out_q.push_back(q_a);
      @(posedge clk);
      #1;
      cyc++;
    end
    last_cyc = cyc;
    in_valid_a = 1'b0;
    q_ready_a = 1'b1;
  endtask

  task automatic clear_stream();
    src_in.delete();
    src_mode.delete();
    out_q.delete();
    acc_cnt = 0;
    hold_err = 0;
    stall_cyc = 0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (q_a !== 1'b0 || q_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: q=%b q_valid=%b, required q=0 q_valid=0", q_a, q_valid_a);
    end
    @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_a !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready_a);
    end
    // Two items in flight, consumer stalled, then reset lands between edges.
    @(posedge clk);
    #1;
    q_ready_a = 1'b0;
    in_valid_a = 1'b1;
    in_a = 16'h0010;
    mode_a = 2'b00;
    @(posedge clk);
    #1 in_a = 16'h0100;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (q_valid_a !== 1'b1 || q_a !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_inflight: q=%b q_valid=%b, required q=1 q_valid=1", q_a, q_valid_a);
    end
    #2 rstb = 1'b0;
    #1;
    n_cmp++;
    if (q_a !== 1'b0 || q_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: q=%b q_valid=%b, required q=0 q_valid=0", q_a, q_valid_a);
    end
    @(posedge clk);
    #1;
    rstb = 1'b1;
    q_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (q_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_stale: cycle %0d q_valid=%b in_ready=%b, required 0 and 1", i, q_valid_a, in_ready_a);
      end
    end
    $display("reset: two in-flight items discarded");
  endtask

  task automatic test_defaults();
    q_ready_a = 1'b1;
    in_a = 16'h0000;
    mode_a = 2'b00;
    in_valid_a = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_a !== 1'b1) begin
      n_bad++;
      $display("FAIL defaults_ready: in_ready=%b, required 1", in_ready_a);
    end
    @(posedge clk);
    #1 in_a = 16'h0400;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (q_valid_a !== 1'b1 || q_a !== 1'b0) begin
      n_bad++;
      $display("FAIL defaults_first: q=%b q_valid=%b, required q=0 q_valid=1", q_a, q_valid_a);
    end
    $display("defaults: in=0000 mode=00 q=%b", q_a);
    @(negedge clk);
    n_cmp++;
    if (q_valid_a !== 1'b1 || q_a !== 1'b1) begin
      n_bad++;
      $display("FAIL defaults_second: q=%b q_valid=%b, required q=1 q_valid=1", q_a, q_valid_a);
    end
    $display("defaults: in=0400 mode=00 q=%b", q_a);
    @(negedge clk);
    n_cmp++;
    if (q_valid_a !== 1'b0) begin
      n_bad++;
      $display("FAIL defaults_drain: q_valid=%b, required 0", q_valid_a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    logic exp_q[4];
    clear_stream();
    src_in.push_back(16'hFFFF); src_mode.push_back(2'b10); exp_q[0] = 1'b1;
    src_in.push_back(16'hFFFF); src_mode.push_back(2'b11); exp_q[1] = 1'b0;
    src_in.push_back(16'hFFFE); src_mode.push_back(2'b10); exp_q[2] = 1'b0;
    src_in.push_back(16'h0000); src_mode.push_back(2'b01); exp_q[3] = 1'b1;
    run_a(4, 100, 100, 40);
    n_cmp++;
    if (out_q.size() != 4) begin
      n_bad++;
      $display("FAIL modes_count: got %0d outputs, required 4", out_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL modes_item%0d: q=%b, required %b", i, out_q[i], exp_q[i]);
      end
      $display("modes: in=%h mode=%b q=%b", src_in[i], src_mode[i], out_q[i]);
    end
  endtask

  task automatic test_padding();
    logic [4:0] p_in[4];
    logic [1:0] p_mode[4];
    logic       p_exp[4];
    int         k;
    p_in[0] = 5'b11111; p_mode[0] = 2'b10; p_exp[0] = 1'b1;
    p_in[1] = 5'b10000; p_mode[1] = 2'b00; p_exp[1] = 1'b1;
    p_in[2] = 5'b01111; p_mode[2] = 2'b10; p_exp[2] = 1'b0;
    p_in[3] = 5'b00000; p_mode[3] = 2'b01; p_exp[3] = 1'b1;
    q_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_b = p_in[i];
      mode_b = p_mode[i];
      in_valid_b = 1'b1;
      @(posedge clk);
      #1 in_valid_b = 1'b0;
      k = 0;
      while (k < 10) begin
        @(negedge clk);
        k++;
        if (q_valid_b) break;
      end
      n_cmp++;
      if (q_valid_b !== 1'b1 || k != 2) begin
        n_bad++;
        $display("FAIL padding_latency%0d: seen after %0d cycles (q_valid=%b), required 2", i, k, q_valid_b);
      end
      n_cmp++;
      if (q_b !== p_exp[i]) begin
        n_bad++;
        $display("FAIL padding_item%0d: q=%b, required %b", i, q_b, p_exp[i]);
      end
      $display("padding: in=%b mode=%b q=%b", p_in[i], p_mode[i], q_b);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_pressure();
    logic exp_q[4];
    clear_stream();
    src_in.push_back(16'h0001); src_mode.push_back(2'b00); exp_q[0] = 1'b1;
    src_in.push_back(16'h0000); src_mode.push_back(2'b00); exp_q[1] = 1'b0;
    src_in.push_back(16'hFFFF); src_mode.push_back(2'b10); exp_q[2] = 1'b1;
    src_in.push_back(16'h1234); src_mode.push_back(2'b01); exp_q[3] = 1'b0;
    run_a(4, 100, 0, 6);
    n_cmp++;
    if (acc_cnt != LEV_A || last_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_fill: accepted %0d in_ready=%b, required %0d and 0", acc_cnt, last_in_ready, LEV_A);
    end
    run_a(4, 100, 100, 40);
    n_cmp++;
    if (out_q.size() != 4 || hold_err != 0) begin
      n_bad++;
      $display("FAIL bp_drain: outputs=%0d hold_errors=%0d, required 4 and 0", out_q.size(), hold_err);
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_item%0d: q=%b, required %b", i, out_q[i], exp_q[i]);
      end
      $display("back_pressure: in=%h mode=%b q=%b", src_in[i], src_mode[i], out_q[i]);
    end
  endtask

  task automatic fill_random(input int n);
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(3))
        0: v = 16'h0000;
        1: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      src_in.push_back(v);
      src_mode.push_back(2'($urandom_range(3)));
    end
  endtask

  task automatic test_random();
    int shown;
    clear_stream();
    fill_random(10000);
    run_a(10000, 50, 50, 80000);
    n_cmp++;
    if (out_q.size() != 10000 || hold_err != 0) begin
      n_bad++;
      $display("FAIL random_count: outputs=%0d hold_errors=%0d, required 10000 and 0", out_q.size(), hold_err);
    end
    shown = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== ref_reduce(src_in[i], src_mode[i])) begin
        n_bad++;
        if (shown < 10) begin
          $display("FAIL random_item%0d: in=%h mode=%b q=%b, required %b",
                   i, src_in[i], src_mode[i], out_q[i], ref_reduce(src_in[i], src_mode[i]));
          shown++;
        end
      end
    end
    $display("random: %0d items scored", out_q.size());
  endtask

  task automatic test_back_to_back();
    clear_stream();
    fill_random(100);
    run_a(100, 100, 100, 300);
    n_cmp++;
    if (out_q.size() != 100 || stall_cyc != 0 || last_cyc != 100 + LEV_A) begin
      n_bad++;
      $display("FAIL throughput: outputs=%0d stalls=%0d cycles=%0d, required 100, 0, %0d",
               out_q.size(), stall_cyc, last_cyc, 100 + LEV_A);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      n_cmp++;
      if (out_q[i] !== ref_reduce(src_in[i], src_mode[i])) begin
        n_bad++;
        $display("FAIL b2b_item%0d: q=%b, required %b", i, out_q[i], ref_reduce(src_in[i], src_mode[i]));
      end
    end
    $display("back_to_back: %0d items in %0d cycles", out_q.size(), last_cyc);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstb = 1'b0;
    in_a = '0; mode_a = 2'b00; in_valid_a = 1'b0; q_ready_a = 1'b1;
    in_b = '0; mode_b = 2'b00; in_valid_b = 1'b0; q_ready_b = 1'b1;
    acc_cnt = 0; hold_err = 0; stall_cyc = 0; last_cyc = 0; last_in_ready = 1'b0;
    test_reset();
    test_defaults();
    test_modes();
    test_padding();
    test_back_pressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
